ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, consuming the operand and control outputs of the decode/execute pipeline register. It executes MULT, MULTU, DIV and DIVU over 33 cycles into architectural HI/LO registers and handles MTHI/MTLO writes. While it computes, it raises a registered stall back to the PC, IF/ID and ID/EX registers and the hazard logic.

---
 rtl/ex_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative 33-cycle multiply/divide with HI/LO registers.
// Raises a registered busy stall while an operation is in flight.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_Start,
  input  logic [1:0]       in_Op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_MTHI,
  input  logic             in_MTLO,
  output logic [WIDTH-1:0] out_HI,
  output logic [WIDTH-1:0] out_LO,
  output logic             out_Busy,
  output logic             out_Done
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               div_q, div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sgn_op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Next-state: operand capture, one shift-add/subtract step, sign fix-up
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    sgn_op = ~in_Op[0];
    sa     = in_A[WIDTH-1];
    sb     = in_B[WIDTH-1];
    abs_a  = (sgn_op && sa) ? -in_A : in_A;
    abs_b  = (sgn_op && sb) ? -in_B : in_B;

    trial = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + (b_q[0] ? {1'b0, a_q} : '0);
    prod  = neg_lo_q ? -acc_q : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_Start) begin
          a_d     = abs_a;
          b_d     = abs_b;
          div_d   = in_Op[1];
          // A zero divisor keeps the all-ones quotient unsigned
          neg_lo_d = sgn_op & (sa ^ sb)
                   & (~in_Op[1] | (|in_B));
          neg_hi_d = sgn_op & in_Op[1] & sa;
          acc_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          if (in_MTHI) hi_d = in_A;
          if (in_MTLO) lo_d = in_A;
        end
      end
      S_RUN: begin
        if (div_q) begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          lo_d = neg_lo_q ? -a_q : a_q;
          hi_d = neg_hi_q ? -rem_q : rem_q;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and architectural register update
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out_HI   = hi_q;
  assign out_LO   = lo_q;
  assign out_Busy = busy_q;
  assign out_Done = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed checks of ex_muldiv_unit.
// Hand-computed HI/LO, busy/done timing, MTHI/MTLO and reset.
module tb_ex_muldiv_unit;

  logic        Clk;
  logic        Rst_n;
  logic        in_Start;
  logic [1:0]  in_Op;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic        in_MTHI;
  logic        in_MTLO;
  logic [31:0] out_HI;
  logic [31:0] out_LO;
  logic        out_Busy;
  logic        out_Done;

  int checks;
  int errors;
  int done_seen;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  ex_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .in_Start (in_Start),
    .in_Op    (in_Op),
    .in_A     (in_A),
    .in_B     (in_B),
    .in_MTHI  (in_MTHI),
    .in_MTLO  (in_MTLO),
    .out_HI   (out_HI),
    .out_LO   (out_LO),
    .out_Busy (out_Busy),
    .out_Done (out_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next posedge (E0) and follow it to E34
  task automatic run_op(input string tag,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input bit mtlo_mid,
                        input logic [31:0] prev_lo);
    @(negedge Clk);
    in_Start = 1'b1;
    in_Op    = op;
    in_A     = a;
    in_B     = b;
    @(negedge Clk);
    in_Start = 1'b0;
    in_A     = 32'h0;
    in_B     = 32'h0;
    check({tag, " busy_E0"}, {31'b0, out_Busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (mtlo_mid && i == 10) begin
        in_MTLO = 1'b1;
        in_A    = 32'hDEADBEEF;
      end
      @(negedge Clk);
      if (mtlo_mid && i == 10) begin
        in_MTLO = 1'b0;
        in_A    = 32'h0;
        check({tag, " lo_hold_mtlo"}, out_LO, prev_lo);
      end
    end
    check({tag, " busy_E32"}, {31'b0, out_Busy}, 32'd1);
    check({tag, " done_E32"}, {31'b0, out_Done}, 32'd0);
    @(negedge Clk);
    check({tag, " busy_E33"}, {31'b0, out_Busy}, 32'd0);
    check({tag, " done_E33"}, {31'b0, out_Done}, 32'd1);
    check({tag, " hi"}, out_HI, ehi);
    check({tag, " lo"}, out_LO, elo);
    @(negedge Clk);
    check({tag, " done_E34"}, {31'b0, out_Done}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    Rst_n     = 1'b0;
    in_Start  = 1'b0;
    in_Op     = 2'b00;
    in_A      = 32'h0;
    in_B      = 32'h0;
    in_MTHI   = 1'b0;
    in_MTLO   = 1'b0;

    repeat (2) @(negedge Clk);
    check("rst hi", out_HI, 32'h0);
    check("rst lo", out_LO, 32'h0);
    check("rst busy", {31'b0, out_Busy}, 32'd0);
    check("rst done", {31'b0, out_Done}, 32'd0);
    Rst_n = 1'b1;

    run_op("mult_m3x7", OP_MULT, 32'hFFFFFFFD, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32'h0);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 32'h0);
    run_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32'h0);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0,
           32'd100, 32'hFFFFFFFF, 1'b0, 32'h0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000, 1'b0, 32'h0);
    run_op("div_m5by0", OP_DIV, 32'hFFFFFFFB, 32'd0,
           32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 32'h0);

    // MTHI alone in IDLE
    @(negedge Clk);
    in_MTHI = 1'b1;
    in_A    = 32'h12345678;
    @(negedge Clk);
    in_MTHI = 1'b0;
    check("mthi hi", out_HI, 32'h12345678);
    check("mthi lo_keep", out_LO, 32'hFFFFFFFF);
    check("mthi busy", {31'b0, out_Busy}, 32'd0);
    check("mthi done", {31'b0, out_Done}, 32'd0);

    // MTHI and MTLO together
    in_MTHI = 1'b1;
    in_MTLO = 1'b1;
    in_A    = 32'hCAFEF00D;
    @(negedge Clk);
    in_MTHI = 1'b0;
    in_MTLO = 1'b0;
    check("mtboth hi", out_HI, 32'hCAFEF00D);
    check("mtboth lo", out_LO, 32'hCAFEF00D);

    // Start wins over MTHI at the same edge
    in_MTHI = 1'b1;
    run_op("start_prio", OP_MULTU, 32'd3, 32'd5,
           32'h0, 32'd15, 1'b0, 32'h0);
    in_MTHI = 1'b0;

    // MTLO pulsed mid-RUN is ignored
    run_op("mtlo_run", OP_MULTU, 32'd6, 32'd7,
           32'h0, 32'd42, 1'b1, 32'd15);

    // Back-to-back: DIV held in EX until the MULT completes
    @(negedge Clk);
    in_Start = 1'b1;
    in_Op    = OP_MULT;
    in_A     = 32'hFFFFFFFD;
    in_B     = 32'd7;
    @(negedge Clk);
    in_Op    = OP_DIV;
    in_A     = 32'hFFFFFFF9;
    in_B     = 32'd2;
    check("b2b busy_E0", {31'b0, out_Busy}, 32'd1);
    repeat (33) @(negedge Clk);
    check("b2b done_E34", {31'b0, out_Done}, 32'd1);
    check("b2b busy_E34", {31'b0, out_Busy}, 32'd0);
    check("b2b mult_hi", out_HI, 32'hFFFFFFFF);
    check("b2b mult_lo", out_LO, 32'hFFFFFFEB);
    @(negedge Clk);
    in_Start = 1'b0;
    check("b2b div_accept", {31'b0, out_Busy}, 32'd1);
    check("b2b done_low", {31'b0, out_Done}, 32'd0);
    repeat (32) @(negedge Clk);
    check("b2b done_E67", {31'b0, out_Done}, 32'd0);
    @(negedge Clk);
    check("b2b done_E68", {31'b0, out_Done}, 32'd1);
    check("b2b div_hi", out_HI, 32'hFFFFFFFF);
    check("b2b div_lo", out_LO, 32'hFFFFFFFD);

    // Reset asserted mid-RUN
    @(negedge Clk);
    in_Start = 1'b1;
    in_Op    = OP_MULTU;
    in_A     = 32'h0000FFFF;
    in_B     = 32'h0000FFFF;
    @(negedge Clk);
    in_Start = 1'b0;
    repeat (9) @(posedge Clk);
    #2;
    check("rstmid busy_pre", {31'b0, out_Busy}, 32'd1);
    Rst_n = 1'b0;
    #1;
    check("rstmid busy", {31'b0, out_Busy}, 32'd0);
    check("rstmid done", {31'b0, out_Done}, 32'd0);
    check("rstmid hi", out_HI, 32'h0);
    check("rstmid lo", out_LO, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (out_Done) done_seen++;
    end
    check("rstmid no_done", done_seen, 32'd0);
    check("rstmid idle", {31'b0, out_Busy}, 32'd0);

    run_op("post_rst", OP_MULTU, 32'h00010000, 32'h00010000,
           32'h1, 32'h0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
